// File: rtl/burst_ram_emulator.sv
// Behavioural DRAM-controller stand-in: 4-word bursts over a 64-bit word store, with
// a power-up calibration delay, fixed read latency and a minimum command spacing.
module burst_ram_emulator #(
  parameter int unsigned DEPTH_BITWIDTH   = 12,
  parameter int unsigned ADDRESS_BITWIDTH = 21,
  parameter int unsigned READ_DELAY       = 4,
  parameter int unsigned COMMAND_INTERVAL = 14,
  parameter int unsigned INIT_CYCLES      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd,
  input  logic                        cmd_en,
  input  logic [ADDRESS_BITWIDTH-1:0] addr,
  input  logic [63:0]                 wr_data,
  input  logic [7:0]                  data_mask,
  output logic [63:0]                 rd_data,
  output logic                        rd_data_valid,
  output logic                        busy,
  output logic                        init_calib,
  output logic                        cmd_error
);

  localparam int unsigned Words = 2 ** DEPTH_BITWIDTH;
  localparam int unsigned IvlW  = $clog2(COMMAND_INTERVAL + 1);
  localparam int unsigned InitW = $clog2(INIT_CYCLES + 1);
  localparam int unsigned WaitW = $clog2(READ_DELAY + 1);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StReadWait,
    StReadBurst,
    StWriteBurst
  } state_e;

  state_e                    state_q, state_d;
  logic [InitW-1:0]          init_cnt_q, init_cnt_d;
  logic [IvlW-1:0]           ivl_q, ivl_d;
  logic [WaitW-1:0]          wait_q, wait_d;
  logic [1:0]                beat_q, beat_d;
  logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
  logic [63:0]               rd_data_q, rd_data_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      init_calib_q, init_calib_d;
  logic                      cmd_error_q, cmd_error_d;

  logic [63:0]               mem_q [Words];
  logic                      mem_we;
  logic [DEPTH_BITWIDTH-1:0] mem_waddr;
  logic                      accept;
  logic                      unused_inputs;

  // Byte mask and high address bits exist only for interface compatibility.
  assign unused_inputs = ^{data_mask, addr};

  assign busy   = (state_q != StIdle) || (ivl_q != '0);
  assign accept = cmd_en && !busy;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    init_calib_d = init_calib_q;
    ivl_d        = ivl_q;
    wait_d       = wait_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    cmd_error_d  = cmd_error_q | (cmd_en & busy);
    mem_we       = 1'b0;
    mem_waddr    = addr_q + DEPTH_BITWIDTH'(beat_q);

    if (ivl_q != '0) begin
      ivl_d = ivl_q - IvlW'(1);
    end

    unique case (state_q)
      StInit: begin
        if (init_cnt_q == InitW'(INIT_CYCLES - 1)) begin
          state_d      = StIdle;
          init_calib_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + InitW'(1);
        end
      end
      StIdle: begin
        if (accept) begin
          // Counter holds busy cycles after T+1, so the next command lands at T+INTERVAL.
          ivl_d  = IvlW'(COMMAND_INTERVAL - 1);
          addr_d = addr[DEPTH_BITWIDTH-1:0];
          if (cmd) begin
            mem_we    = 1'b1;
            mem_waddr = addr[DEPTH_BITWIDTH-1:0];
            beat_d    = 2'd1;
            state_d   = StWriteBurst;
          end else begin
            wait_d  = WaitW'(READ_DELAY - 1);
            beat_d  = 2'd0;
            state_d = StReadWait;
          end
        end
      end
      StReadWait: begin
        if (wait_q == WaitW'(1)) begin
          state_d    = StReadBurst;
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[addr_q];
          beat_d     = 2'd0;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StReadBurst: begin
        if (beat_q == 2'd3) begin
          state_d = StIdle;
        end else begin
          rd_valid_d = 1'b1;
          beat_d     = beat_q + 2'd1;
          rd_data_d  = mem_q[addr_q + DEPTH_BITWIDTH'(beat_q + 2'd1)];
        end
      end
      StWriteBurst: begin
        mem_we = 1'b1;
        if (beat_q == 2'd3) begin
          state_d = StIdle;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      init_calib_q <= 1'b0;
      ivl_q        <= '0;
      wait_q       <= '0;
      beat_q       <= '0;
      addr_q       <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_calib_q <= init_calib_d;
      ivl_q        <= ivl_d;
      wait_q       <= wait_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  // Storage survives reset; reset only stops further writes via the state register.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= wr_data;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign init_calib    = init_calib_q;
  assign cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_burst_ram_emulator.sv
// Bench for burst_ram_emulator: vector table, targeted timing/reset sequences and a
// randomized run against an array model of the word store.
module tb_burst_ram_emulator;

  localparam int AW = 21;
  localparam int DW = 12;
  localparam int NW = 4096;
  localparam int RD = 4;
  localparam int IC = 10;

  typedef logic [3:0][63:0] burst_t;

  typedef struct {
    bit            do_wr;
    logic [AW-1:0] waddr;
    burst_t        wdata;
    logic [AW-1:0] raddr;
    burst_t        exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd;
  logic          cmd_en;
  logic [AW-1:0] addr;
  logic [63:0]   wr_data;
  logic [7:0]    data_mask;
  logic [63:0]   rd_data;
  logic          rd_data_valid;
  logic          busy;
  logic          init_calib;
  logic          cmd_error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_acc    = 0;

  logic [63:0]   model_mem [NW];
  bit            model_vld [NW];
  logic [AW-1:0] wq [$];
  vec_t          vecs [5];
  logic [AW-1:0] ra;
  burst_t        rb;
  burst_t        old_b;

  burst_ram_emulator dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .cmd_en       (cmd_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .data_mask    (data_mask),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .busy         (busy),
    .init_calib   (init_calib),
    .cmd_error    (cmd_error)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic burst_t mk4(input logic [63:0] w0, input logic [63:0] w1,
                                 input logic [63:0] w2, input logic [63:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic burst_t model_burst(input logic [AW-1:0] a);
    burst_t r;
    for (int i = 0; i < 4; i++) r[i] = model_mem[(int'(a) + i) % NW];
    return r;
  endfunction

  function automatic logic [3:0] model_mask(input logic [AW-1:0] a);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = model_vld[(int'(a) + i) % NW];
    return m;
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk1({nm, "_ready"}, busy, 1'b0);
  endtask

  task automatic accept(input bit w, input logic [AW-1:0] a, input logic [63:0] d0,
                        input string nm);
    chk1({nm, "_busy_T"}, busy, 1'b0);
    cmd_en  = 1'b1;
    cmd     = w;
    addr    = a;
    wr_data = d0;
    t_acc   = cyc;
    step();
    cmd_en  = 1'b0;
    cmd     = 1'($urandom);
    addr    = AW'($urandom);
    chk1({nm, "_busy_T1"}, busy, 1'b1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input burst_t d, input string nm);
    accept(1'b1, a, d[0], nm);
    for (int i = 1; i < 4; i++) begin
      wr_data = d[i];
      step();
    end
    wr_data = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      model_mem[(int'(a) + i) % NW] = d[i];
      model_vld[(int'(a) + i) % NW] = 1'b1;
    end
    wq.push_back(a);
  endtask

  // inj > 0 pulses an illegal write to 0x100 at T+inj.
  task automatic do_read(input logic [AW-1:0] a, input burst_t exp, input logic [3:0] m,
                         input int inj, input string nm);
    accept(1'b0, a, 64'h0, nm);
    for (int k = 1; k <= RD + 4; k++) begin
      if (k == inj) begin
        cmd_en  = 1'b1;
        cmd     = 1'b1;
        addr    = 21'h100;
        wr_data = {$urandom, $urandom};
      end
      chk1($sformatf("%s_valid_T%0d", nm, k), rd_data_valid, (k >= RD && k < RD + 4));
      if (k >= RD && k < RD + 4 && m[k-RD])
        chk64($sformatf("%s_word%0d", nm, k - RD), rd_data, exp[k-RD]);
      step();
      cmd_en = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd       = 1'b0;
    cmd_en    = 1'b0;
    addr      = '0;
    wr_data   = '0;
    data_mask = '0;
    for (int i = 0; i < NW; i++) model_vld[i] = 1'b0;

    vecs[0] = '{1'b1, 21'h008,
                mk4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444),
                21'h008,
                mk4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444)};
    vecs[1] = '{1'b1, 21'h000,
                mk4(64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
                    64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3),
                21'h000,
                mk4(64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
                    64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3)};
    // Wrapping write: last two words overwrite 0x000/0x001.
    vecs[2] = '{1'b1, 21'h0FFE,
                mk4(64'hB0B0_DEAD_BEEF_00B0, 64'hB1B1_DEAD_BEEF_00B1,
                    64'hB2B2_DEAD_BEEF_00B2, 64'hB3B3_DEAD_BEEF_00B3),
                21'h000,
                mk4(64'hB2B2_DEAD_BEEF_00B2, 64'hB3B3_DEAD_BEEF_00B3,
                    64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3)};
    vecs[3] = '{1'b0, 21'h000, '0, 21'h0FFE,
                mk4(64'hB0B0_DEAD_BEEF_00B0, 64'hB1B1_DEAD_BEEF_00B1,
                    64'hB2B2_DEAD_BEEF_00B2, 64'hB3B3_DEAD_BEEF_00B3)};
    // High address bits are ignored.
    vecs[4] = '{1'b1, 21'h1F_FF00,
                mk4(64'hC0, 64'hC1, 64'hC2, 64'hC3),
                21'h00_0F00,
                mk4(64'hC0, 64'hC1, 64'hC2, 64'hC3)};

    // Reset state and calibration delay.
    repeat (3) step();
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_init_calib", init_calib, 1'b0);
    chk1("rst_valid", rd_data_valid, 1'b0);
    chk1("rst_cmd_error", cmd_error, 1'b0);
    chk64("rst_rd_data", rd_data, 64'h0);
    rst = 1'b0;
    for (int k = 0; k < IC; k++) begin
      chk1($sformatf("init_low_%0d", k), init_calib, 1'b0);
      chk1($sformatf("init_busy_%0d", k), busy, 1'b1);
      step();
    end
    chk1("init_done", init_calib, 1'b1);
    chk1("init_busy_clear", busy, 1'b0);
    chk1("init_no_error", cmd_error, 1'b0);

    for (int v = 0; v < 5; v++) begin
      wait_ready($sformatf("vec%0d_pre", v));
      if (vecs[v].do_wr) begin
        do_write(vecs[v].waddr, vecs[v].wdata, $sformatf("vec%0d_wr", v));
        wait_ready($sformatf("vec%0d_mid", v));
      end
      do_read(vecs[v].raddr, vecs[v].exp, 4'hF, 0, $sformatf("vec%0d_rd", v));
    end

    // Back-to-back: read accepted exactly when busy first drops.
    wait_ready("b2b_pre");
    do_write(21'h100, mk4({$urandom, $urandom}, {$urandom, $urandom},
                          {$urandom, $urandom}, {$urandom, $urandom}), "b2b_wr");
    while (cyc < t_acc + 13) step();
    chk1("b2b_busy_T13", busy, 1'b1);
    step();
    chk1("b2b_busy_T14", busy, 1'b0);
    do_read(21'h100, model_burst(21'h100), model_mask(21'h100), 0, "b2b_rd");

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      wait_ready("rnd_pre");
      repeat ($urandom_range(0, 2)) step();
      data_mask = 8'($urandom);
      if ($urandom_range(0, 1) == 1 || wq.size() == 0) begin
        ra = AW'($urandom);
        if ($urandom_range(0, 3) == 0) ra[DW-1:0] = 12'hFFC + 12'($urandom_range(0, 3));
        rb = mk4({$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom});
        do_write(ra, rb, $sformatf("rnd%0d_wr", n));
      end else begin
        ra = wq[$urandom_range(0, wq.size() - 1)] + AW'($urandom_range(0, 3));
        ra[AW-1:DW] = (AW - DW)'($urandom);
        do_read(ra, model_burst(ra), model_mask(ra), 0, $sformatf("rnd%0d_rd", n));
      end
    end

    // Illegal command mid-read: ignored, error sticky, next slot at T+14 accepted.
    wait_ready("err_pre");
    chk1("err_clear", cmd_error, 1'b0);
    do_read(21'h008, model_burst(21'h008), model_mask(21'h008), 5, "err_rd");
    chk1("err_set", cmd_error, 1'b1);
    while (cyc < t_acc + 14) step();
    do_write(21'h200, mk4(64'hE0, 64'hE1, 64'hE2, 64'hE3), "err_next_wr");
    chk1("err_sticky", cmd_error, 1'b1);
    wait_ready("err_rd2_pre");
    do_read(21'h100, model_burst(21'h100), model_mask(21'h100), 0, "err_ignored_wr");
    wait_ready("err_rd3_pre");
    do_read(21'h200, model_burst(21'h200), model_mask(21'h200), 0, "err_next_rd");

    // Reset mid-write: only words already written persist.
    wait_ready("rstw_pre");
    old_b = mk4(64'hF0, 64'hF1, 64'hF2, 64'hF3);
    do_write(21'h300, old_b, "rstw_old");
    wait_ready("rstw_pre2");
    rb = mk4(64'h9990, 64'h9991, 64'h9992, 64'h9993);
    accept(1'b1, 21'h300, rb[0], "rstw");
    wr_data = rb[1];
    step();
    wr_data = rb[2];
    #2 rst = 1'b1;
    #1;
    model_mem[12'h300] = rb[0];
    model_mem[12'h301] = rb[1];
    chk1("rstw_busy", busy, 1'b1);
    chk1("rstw_init_calib", init_calib, 1'b0);
    chk1("rstw_cmd_error", cmd_error, 1'b0);
    step();
    step();
    rst     = 1'b0;
    cmd_en  = 1'b1;
    cmd     = 1'b1;
    addr    = 21'h300;
    wr_data = 64'h5555;
    step();
    cmd_en  = 1'b0;
    chk1("init_cmd_error", cmd_error, 1'b1);
    chk1("init_still_low", init_calib, 1'b0);
    wait_ready("rstw_reinit");
    do_read(21'h300, model_burst(21'h300), 4'hF, 0, "rstw_partial");

    // Reset during the second read word.
    wait_ready("rsta_pre");
    accept(1'b0, 21'h300, 64'h0, "rsta");
    while (cyc < t_acc + 5) step();
    chk1("rsta_valid_w1", rd_data_valid, 1'b1);
    chk64("rsta_word1", rd_data, model_mem[12'h301]);
    #2 rst = 1'b1;
    #1;
    chk1("rsta_valid_drop", rd_data_valid, 1'b0);
    chk64("rsta_rd_data_zero", rd_data, 64'h0);
    step();
    chk1("rsta_valid_held", rd_data_valid, 1'b0);
    rst = 1'b0;
    step();
    chk1("rsta_no_more_words", rd_data_valid, 1'b0);
    wait_ready("rsta_reinit");
    do_read(21'h300, model_burst(21'h300), 4'hF, 0, "rsta_after");
    wait_ready("rsta_pre2");
    do_read(21'h008, model_burst(21'h008), model_mask(21'h008), 0, "rsta_old_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_ram_emulator.md
BURST_RAM_EMULATOR -- requirements
Module: burst_ram_emulator

Interface
REQ-001 Parameter DEPTH_BITWIDTH, default 12: storage holds 2^DEPTH_BITWIDTH 64-bit words.
REQ-002 Parameter ADDRESS_BITWIDTH, default 21: width of addr port; upper bits beyond DEPTH_BITWIDTH ignored.
REQ-003 Parameter READ_DELAY, default 4: cycles from accepted read command to first rd_data_valid.
REQ-004 Parameter COMMAND_INTERVAL, default 14: minimum cycles between accepted commands.
REQ-005 Parameter INIT_CYCLES, default 10: cycles after reset release before init_calib asserts.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 cmd  in  1  0: read, 1: write; sampled with cmd_en.
REQ-009 cmd_en  in  1  command and addr valid this cycle.
REQ-010 addr  in  ADDRESS_BITWIDTH  burst start address in 8-byte words.
REQ-011 wr_data  in  64  write data; first word on cmd_en cycle, then 3 consecutive cycles.
REQ-012 data_mask  in  8  accepted for compatibility, ignored; all bytes always written.
REQ-013 rd_data  out  64  read data word.
REQ-014 rd_data_valid  out  1  rd_data valid this cycle.
REQ-015 busy  out  1  high when a command would not be accepted.
REQ-016 init_calib  out  1  high once initialisation complete; stays high until reset.
REQ-017 cmd_error  out  1  sticky: command issued while busy or before init_calib.

Function
REQ-018 States: INIT, IDLE, READ_WAIT, READ_BURST, WRITE_BURST; interval counter runs independently of state.
REQ-019 INIT: count INIT_CYCLES, then init_calib=1 and go IDLE; busy=1 throughout INIT.
REQ-020 Command accepted only when cmd_en=1 and busy=0 in IDLE; acceptance cycle = T.
REQ-021 On acceptance interval counter loads COMMAND_INTERVAL; busy=1 from T+1 until counter reaches 0 and state is IDLE.
REQ-022 Read: IDLE->READ_WAIT at T; rd_data_valid=1 exactly on cycles T+READ_DELAY .. T+READ_DELAY+3, contiguous.
REQ-023 Read burst word i (0..3) = mem[(addr+i) mod 2^DEPTH_BITWIDTH]; READ_BURST->IDLE after 4th word.
REQ-024 rd_data held at last driven value when rd_data_valid=0; value not relied upon.
REQ-025 Write: wr_data at T written to mem[addr], at T+1..T+3 to addr+1..addr+3 (same wrap); WRITE_BURST->IDLE after 4th word.
REQ-026 Write data visible to any read command accepted after the write burst completes.
REQ-027 Address wrap: burst crossing top of storage continues at word 0.
REQ-028 cmd_en while busy=1 or init_calib=0: command ignored, no state change, cmd_error set to 1 next cycle.
REQ-029 cmd_en on cycle busy falls to 0: accepted normally (no extra dead cycle).
REQ-030 cmd ignored when cmd_en=0; wr_data ignored outside write burst cycles.

Reset
REQ-031 Assertion of rst immediately (asynchronously) forces: state INIT, rd_data_valid=0, rd_data=0, busy=1, init_calib=0, cmd_error=0, counters 0.
REQ-032 Reset mid-burst aborts burst; partially written words remain; storage contents otherwise preserved (not cleared).
REQ-033 After rst deasserts, INIT sequence per REQ-019 restarts.

Verification
REQ-034 Reset release, no commands -> busy=1, init_calib=0 for 10 cycles; then init_calib=1, busy=0, cmd_error=0.
REQ-035 Write addr=0x8, data 0x1111..,0x2222..,0x3333..,0x4444.. on T..T+3; read addr=0x8 after busy falls -> rd_data_valid on T'+4..T'+7 with same four words in order.
REQ-036 Write burst at addr=0xFFE (DEPTH_BITWIDTH=12) -> words land at 0xFFE,0xFFF,0x000,0x001; read back at 0x000 returns 3rd,4th words first.
REQ-037 cmd_en pulsed at T+5 after accepted read -> ignored, cmd_error=1 and stays 1; original burst unaffected; next command at T+14 accepted.
REQ-038 rst asserted during READ_BURST 2nd word -> rd_data_valid drops same cycle, no further words; after re-init, read of earlier written data returns unchanged values.
REQ-039 Back-to-back: write accepted at T, read accepted at T+14 -> busy=0 exactly at T+14; read returns just-written data.
